// File: rtl/serial_addsub_pkg.sv
// -----------------------------------------------------------------------------
// serial_addsub_pkg
// Shared definitions for the bit-serial adder/subtractor:
//   - state_t : FSM state encoding (IDLE / RUN / DONE)
//   - WIDTH_MIN / WIDTH_MAX : legal operand width bounds
// -----------------------------------------------------------------------------
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage : serial_addsub_pkg

// File: rtl/serial_addsub_if.sv
// -----------------------------------------------------------------------------
// serial_addsub_if
// Request/result bundle of the bit-serial adder/subtractor.
//   start, sub, a, b       : request side (driven by the master)
//   busy, done, sum,
//   c_out, ovf             : status/result side (driven by the slave)
// Clock and reset are kept as plain ports on the design.
// -----------------------------------------------------------------------------
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, c_out, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, c_out, ovf
    );
endinterface : serial_addsub_if

// File: rtl/serial_addsub_fa_cell.sv
// -----------------------------------------------------------------------------
// fa_cell
// Purely combinational 1-bit full adder.
//   a, b, c_in : addend bits and carry in
//   s          : sum bit
//   c_out      : carry out
// -----------------------------------------------------------------------------
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule : fa_cell

// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
// Bit-serial adder/subtractor: one result bit per clock, LSB first, through a
// single full-adder cell plus a carry flip-flop. Subtraction is a + ~b + 1,
// with the +1 coming from the initial carry.
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset (aborts any operation in flight)
//   bus   : slave side of serial_addsub_if
//           start/sub/a/b sampled in IDLE or DONE; busy high in RUN;
//           done one-cycle pulse; sum/c_out/ovf held until next completion.
// Latency: start at edge E0 -> done high from E(WIDTH) to E(WIDTH+1).
// -----------------------------------------------------------------------------
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    serial_addsub_if.slave bus
);

    localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

    if ((WIDTH < WIDTH_MIN) || (WIDTH > WIDTH_MAX)) begin : g_bad_width
        $error("serial_addsub: WIDTH out of legal range");
    end

    state_t           state_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    // Holds the WIDTH-1 result bits produced so far; the MSB comes straight
    // from the cell on the completion edge.
    logic [WIDTH-2:0] res_sh_r;
    logic             carry_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             c_out_r;
    logic             ovf_r;

    logic             fa_s_s;
    logic             fa_c_s;
    logic [WIDTH-1:0] res_next_s;

    fa_cell u_fa (
        .a     (a_sh_r[0]),
        .b     (b_sh_r[0]),
        .c_in  (carry_r),
        .s     (fa_s_s),
        .c_out (fa_c_s)
    );

    // New sum bit enters at the top; on the last bit this is the full result.
    assign res_next_s = {fa_s_s, res_sh_r};

    // FSM, datapath shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            a_sh_r   <= {WIDTH{1'b0}};
            b_sh_r   <= {WIDTH{1'b0}};
            res_sh_r <= {(WIDTH-1){1'b0}};
            carry_r  <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            sum_r    <= {WIDTH{1'b0}};
            c_out_r  <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            case (state_r)
                // DONE accepts a new request exactly like IDLE, which gives
                // back-to-back operation.
                ST_IDLE, ST_DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_sh_r  <= bus.a;
                        b_sh_r  <= bus.sub ? ~bus.b : bus.b;
                        carry_r <= bus.sub;
                        cnt_r   <= {CNT_W{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
                    res_sh_r <= res_next_s[WIDTH-1:1];
                    carry_r  <= fa_c_s;
                    if (cnt_r == LAST_CNT) begin
                        // carry_r here is the carry into the MSB.
                        sum_r   <= res_next_s;
                        c_out_r <= fa_c_s;
                        ovf_r   <= carry_r ^ fa_c_s;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                        done_r  <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.sum   = sum_r;
    assign bus.c_out = c_out_r;
    assign bus.ovf   = ovf_r;

endmodule : serial_addsub

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   edges;
    int   seen_done;

    serial_addsub_if #(.WIDTH(8)) bus8 ();
    serial_addsub_if #(.WIDTH(4)) bus4 ();

    serial_addsub #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    serial_addsub #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a request at the current negedge; returns just after edge E0.
    task automatic start8(input logic s, input logic [7:0] av, input logic [7:0] bv);
        bus8.start = 1'b1;
        bus8.sub   = s;
        bus8.a     = av;
        bus8.b     = bv;
        @(negedge clk);
        bus8.start = 1'b0;
    endtask

    // Advance until done is seen, bounded; edges counts edges since E0.
    task automatic wait_done8(inout int n);
        while ((bus8.done !== 1'b1) && (n < 40)) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic result8(input string tag, input int n, input int exp_n,
                           input logic [7:0] s, input logic c, input logic o);
        check({tag, "_latency"}, n, exp_n);
        check({tag, "_done"}, bus8.done, 1'b1);
        check({tag, "_sum"}, bus8.sum, s);
        check({tag, "_cout"}, bus8.c_out, c);
        check({tag, "_ovf"}, bus8.ovf, o);
    endtask

    initial begin
        reset      = 1'b1;
        bus8.start = 1'b0; bus8.sub = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00;
        bus4.start = 1'b0; bus4.sub = 1'b0; bus4.a = 4'h0;  bus4.b = 4'h0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_busy", bus8.busy, 1'b0);
        check("rst_done", bus8.done, 1'b0);
        check("rst_sum",  bus8.sum,  8'h00);
        check("rst_cout", bus8.c_out, 1'b0);
        check("rst_ovf",  bus8.ovf,  1'b0);
        check("rst_sum4", bus4.sum,  4'h0);

        // 0x3C + 0x0A
        start8(1'b0, 8'h3C, 8'h0A);
        edges = 0;
        check("add1_busy_e0", bus8.busy, 1'b1);
        check("add1_sum_held", bus8.sum, 8'h00);
        wait_done8(edges);
        result8("add1", edges, 8, 8'h46, 1'b0, 1'b0);
        check("add1_busy_done", bus8.busy, 1'b0);
        @(negedge clk);
        check("add1_done_pulse", bus8.done, 1'b0);
        check("add1_sum_kept", bus8.sum, 8'h46);

        // 0xFF + 0x01 : wraps, carry out
        start8(1'b0, 8'hFF, 8'h01);
        edges = 0;
        wait_done8(edges);
        result8("add_wrap", edges, 8, 8'h00, 1'b1, 1'b0);
        @(negedge clk);

        // 0x7F + 0x01 : signed overflow
        start8(1'b0, 8'h7F, 8'h01);
        edges = 0;
        wait_done8(edges);
        result8("add_ovf", edges, 8, 8'h80, 1'b0, 1'b1);
        @(negedge clk);

        // 0x05 - 0x07 : borrow
        start8(1'b1, 8'h05, 8'h07);
        edges = 0;
        wait_done8(edges);
        result8("sub_borrow", edges, 8, 8'hFE, 1'b0, 1'b0);
        @(negedge clk);

        // 0x80 - 0x01 : signed overflow, no borrow
        start8(1'b1, 8'h80, 8'h01);
        edges = 0;
        wait_done8(edges);
        result8("sub_ovf", edges, 8, 8'h7F, 1'b1, 1'b1);
        @(negedge clk);

        // start while busy is ignored
        start8(1'b0, 8'h10, 8'h20);
        edges = 0;
        @(negedge clk); edges++;
        @(negedge clk); edges++;
        bus8.start = 1'b1;
        bus8.a     = 8'hFF;
        bus8.sub   = 1'b1;
        @(negedge clk); edges++;
        bus8.start = 1'b0;
        bus8.sub   = 1'b0;
        check("hz_busy_mid", bus8.busy, 1'b1);
        check("hz_sum_stable", bus8.sum, 8'h7F);
        wait_done8(edges);
        result8("hz_ignore", edges, 8, 8'h30, 1'b0, 1'b0);

        // start in the DONE cycle: back-to-back
        start8(1'b0, 8'h01, 8'h01);
        edges++;
        check("b2b_busy", bus8.busy, 1'b1);
        check("b2b_done_low", bus8.done, 1'b0);
        wait_done8(edges);
        result8("b2b", edges, 17, 8'h02, 1'b0, 1'b0);
        @(negedge clk);

        // Reset mid-operation aborts without a done pulse
        start8(1'b0, 8'h11, 8'h22);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", bus8.busy, 1'b0);
        check("abort_sum",  bus8.sum,  8'h00);
        check("abort_done", bus8.done, 1'b0);
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus8.done === 1'b1) seen_done++;
        end
        check("abort_no_done", seen_done, 0);
        start8(1'b0, 8'h11, 8'h22);
        edges = 0;
        wait_done8(edges);
        result8("after_abort", edges, 8, 8'h33, 1'b0, 1'b0);
        @(negedge clk);

        // WIDTH=4 instance: 0 - 0
        bus4.start = 1'b1;
        bus4.sub   = 1'b1;
        bus4.a     = 4'h0;
        bus4.b     = 4'h0;
        @(negedge clk);
        bus4.start = 1'b0;
        edges = 0;
        check("w4_busy", bus4.busy, 1'b1);
        while ((bus4.done !== 1'b1) && (edges < 40)) begin
            @(negedge clk);
            edges++;
        end
        check("w4_latency", edges, 4);
        check("w4_done", bus4.done, 1'b1);
        check("w4_sum",  bus4.sum,  4'h0);
        check("w4_cout", bus4.c_out, 1'b1);
        check("w4_ovf",  bus4.ovf,  1'b0);
        @(negedge clk);
        check("w4_done_pulse", bus4.done, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_addsub
